pixel_pattern_gen: RTL and testbench

Pixel-colour stage directly downstream of the pixel cursor (timing generator).
- Consumes the cursor's x/y coordinates, data-enable and active-high syncs.
- Produces a registered 24-bit RGB pixel with DE/syncs delayed to match; these drive ADV_D/ADV_DE and the inverted ADV_Hsync/ADV_Vsync at top level.
- Selects one of four test patterns, including a bouncing box animated once per frame.

---
 rtl/pixel_pkg.sv | 38 +++
 rtl/pixel_pattern_gen_if.sv | 29 ++
 rtl/box_motion.sv | 67 ++++++
 rtl/pixel_pattern_gen.sv | 143 ++++++++++++++
 tb/tb_pixel_pattern_gen.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_pkg.sv
// Shared constants for the pixel pattern generator: mode encodings, bar palette, pipeline depth.
package pixel_pkg;

  localparam logic [1:0] MODE_SOLID = 2'd0;
  localparam logic [1:0] MODE_BARS  = 2'd1;
  localparam logic [1:0] MODE_CHECK = 2'd2;
  localparam logic [1:0] MODE_BOX   = 2'd3;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  // Cycles from cursor inputs to registered outputs.
  localparam int unsigned PIPE_LATENCY = 2;

  // Colour of bar idx, left (0) to right (7).
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    unique case (idx)
      3'd0: c = BAR_WHITE;
      3'd1: c = BAR_YELLOW;
      3'd2: c = BAR_CYAN;
      3'd3: c = BAR_GREEN;
      3'd4: c = BAR_MAGENTA;
      3'd5: c = BAR_RED;
      3'd6: c = BAR_BLUE;
      3'd7: c = BAR_BLACK;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pixel_pattern_gen_if.sv
// Cursor-side inputs, pattern controls and video outputs of the pattern generator.
interface pixel_pattern_gen_if #(
  parameter int unsigned X_W = 11,
  parameter int unsigned Y_W = 10
);
  logic [X_W-1:0] in_x;
  logic [Y_W-1:0] in_y;
  logic           in_de;
  logic           in_hsync;
  logic           in_vsync;
  logic [1:0]     mode;
  logic [23:0]    colour;
  logic           out_de;
  logic           out_hsync;
  logic           out_vsync;
  logic [23:0]    out_rgb;

  // Driver side (cursor / control).
  modport master (
    output in_x, in_y, in_de, in_hsync, in_vsync, mode, colour,
    input  out_de, out_hsync, out_vsync, out_rgb
  );

  // Pattern generator side.
  modport slave (
    input  in_x, in_y, in_de, in_hsync, in_vsync, mode, colour,
    output out_de, out_hsync, out_vsync, out_rgb
  );
endinterface

// File: rtl/box_motion.sv
// Bouncing-box position: moves one pixel per axis on every frame-start event and reverses
// direction on reaching either edge of the active area.
module box_motion #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned X_W      = 11,
  parameter int unsigned Y_W      = 10,
  parameter int unsigned BOX_SIZE = 32
) (
  input  logic           pix_clk,
  input  logic           RST_N,
  input  logic           frame_start,
  output logic [X_W-1:0] box_x,
  output logic [Y_W-1:0] box_y
);

  localparam logic [X_W-1:0] XMax = X_W'(H_ACTIVE - BOX_SIZE);
  localparam logic [Y_W-1:0] YMax = Y_W'(V_ACTIVE - BOX_SIZE);

  logic [X_W-1:0] box_x_q, box_x_d;
  logic [Y_W-1:0] box_y_q, box_y_d;
  logic           dir_x_q, dir_x_d;  // 1 = increasing
  logic           dir_y_q, dir_y_d;

  // Next position/direction; only changes on a frame-start event.
  always_comb begin
    box_x_d = box_x_q;
    box_y_d = box_y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    if (frame_start) begin
      if (dir_x_q) begin
        box_x_d = box_x_q + 1'b1;
        if (box_x_d == XMax) dir_x_d = 1'b0;
      end else begin
        box_x_d = box_x_q - 1'b1;
        if (box_x_d == '0) dir_x_d = 1'b1;
      end
      if (dir_y_q) begin
        box_y_d = box_y_q + 1'b1;
        if (box_y_d == YMax) dir_y_d = 1'b0;
      end else begin
        box_y_d = box_y_q - 1'b1;
        if (box_y_d == '0) dir_y_d = 1'b1;
      end
    end
  end

  // Position and direction registers.
  always_ff @(posedge pix_clk or negedge RST_N) begin
    if (!RST_N) begin
      box_x_q <= '0;
      box_y_q <= '0;
      dir_x_q <= 1'b1;
      dir_y_q <= 1'b1;
    end else begin
      box_x_q <= box_x_d;
      box_y_q <= box_y_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
    end
  end

  assign box_x = box_x_q;
  assign box_y = box_y_q;

endmodule

// File: rtl/pixel_pattern_gen.sv
// Two-stage pixel colour pipeline: stage 1 classifies the pixel (bar, checker, box),
// stage 2 picks the colour for the frame-latched mode and blanks outside active video.
module pixel_pattern_gen
  import pixel_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned X_W      = 11,
  parameter int unsigned Y_W      = 10,
  parameter int unsigned BOX_SIZE = 32
) (
  input  logic               pix_clk,
  input  logic               RST_N,
  pixel_pattern_gen_if.slave bus
);

  localparam logic [X_W:0] BoxSizeX = (X_W + 1)'(BOX_SIZE);
  localparam logic [Y_W:0] BoxSizeY = (Y_W + 1)'(BOX_SIZE);

  logic           prev_vsync_q;
  logic           frame_start;
  logic [1:0]     mode_q;
  logic [23:0]    colour_q;
  logic [X_W-1:0] box_x;
  logic [Y_W-1:0] box_y;

  logic [2:0]     bar_idx;
  logic           check_bit;
  logic           in_box;
  logic [X_W:0]   x_ext, box_x_end;
  logic [Y_W:0]   y_ext, box_y_end;

  logic           de_s1_q, hs_s1_q, vs_s1_q;
  logic [2:0]     bar_s1_q;
  logic           check_s1_q, in_box_s1_q;

  logic [23:0]    pix_rgb;
  logic           de_s2_q, hs_s2_q, vs_s2_q;
  logic [23:0]    rgb_s2_q;

  assign frame_start = bus.in_vsync & ~prev_vsync_q;

  // Vsync edge detector and per-frame latch of mode/colour.
  always_ff @(posedge pix_clk or negedge RST_N) begin
    if (!RST_N) begin
      prev_vsync_q <= 1'b0;
      mode_q       <= MODE_SOLID;
      colour_q     <= '0;
    end else begin
      prev_vsync_q <= bus.in_vsync;
      if (frame_start) begin
        mode_q   <= bus.mode;
        colour_q <= bus.colour;
      end
    end
  end

  box_motion #(
    .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE),
    .X_W     (X_W),
    .Y_W     (Y_W),
    .BOX_SIZE(BOX_SIZE)
  ) u_box_motion (
    .pix_clk    (pix_clk),
    .RST_N      (RST_N),
    .frame_start(frame_start),
    .box_x      (box_x),
    .box_y      (box_y)
  );

  // Bar index: count of constant thresholds H_ACTIVE*k/8 that x has reached.
  always_comb begin
    bar_idx = '0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (32'(bus.in_x) >= (H_ACTIVE * k) / 8) bar_idx = 3'(k);
    end
  end

  // Checker and box membership; box ends computed one bit wider so they cannot wrap.
  always_comb begin
    check_bit = bus.in_x[5] ^ bus.in_y[5];
    x_ext     = {1'b0, bus.in_x};
    y_ext     = {1'b0, bus.in_y};
    box_x_end = {1'b0, box_x} + BoxSizeX;
    box_y_end = {1'b0, box_y} + BoxSizeY;
    in_box    = (x_ext >= {1'b0, box_x}) && (x_ext < box_x_end) &&
                (y_ext >= {1'b0, box_y}) && (y_ext < box_y_end);
  end

  // Stage 1: timing flags and region classification.
  always_ff @(posedge pix_clk or negedge RST_N) begin
    if (!RST_N) begin
      de_s1_q     <= 1'b0;
      hs_s1_q     <= 1'b0;
      vs_s1_q     <= 1'b0;
      bar_s1_q    <= '0;
      check_s1_q  <= 1'b0;
      in_box_s1_q <= 1'b0;
    end else begin
      de_s1_q     <= bus.in_de;
      hs_s1_q     <= bus.in_hsync;
      vs_s1_q     <= bus.in_vsync;
      bar_s1_q    <= bar_idx;
      check_s1_q  <= check_bit;
      in_box_s1_q <= in_box;
    end
  end

  // Colour select for the latched mode; blanked outside active video.
  always_comb begin
    pix_rgb = '0;
    unique case (mode_q)
      MODE_SOLID: pix_rgb = colour_q;
      MODE_BARS:  pix_rgb = bar_colour(bar_s1_q);
      MODE_CHECK: pix_rgb = check_s1_q ? 24'h000000 : 24'hFFFFFF;
      MODE_BOX:   pix_rgb = in_box_s1_q ? colour_q : 24'h000000;
      default:    pix_rgb = '0;
    endcase
    if (!de_s1_q) pix_rgb = '0;
  end

  // Stage 2: output registers.
  always_ff @(posedge pix_clk or negedge RST_N) begin
    if (!RST_N) begin
      de_s2_q  <= 1'b0;
      hs_s2_q  <= 1'b0;
      vs_s2_q  <= 1'b0;
      rgb_s2_q <= '0;
    end else begin
      de_s2_q  <= de_s1_q;
      hs_s2_q  <= hs_s1_q;
      vs_s2_q  <= vs_s1_q;
      rgb_s2_q <= pix_rgb;
    end
  end

  assign bus.out_de    = de_s2_q;
  assign bus.out_hsync = hs_s2_q;
  assign bus.out_vsync = vs_s2_q;
  assign bus.out_rgb   = rgb_s2_q;

endmodule

// File: tb/tb_pixel_pattern_gen.sv
// Scoreboard bench: the driver queues the expected {de,hsync,vsync,rgb} for checked pixels,
// the monitor pops each entry two cycles later and compares it with the outputs.
module tb_pixel_pattern_gen;

  localparam int Lat = 2;

  logic pix_clk = 1'b0;
  logic RST_N   = 1'b0;
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  typedef struct {
    int          cyc;
    string       name;
    logic [26:0] exp;
  } exp_t;

  exp_t sb[$];

  pixel_pattern_gen_if #(.X_W(11), .Y_W(10)) bus ();

  pixel_pattern_gen #(
    .H_ACTIVE(640),
    .V_ACTIVE(480),
    .X_W     (11),
    .Y_W     (10),
    .BOX_SIZE(32)
  ) dut (
    .pix_clk(pix_clk),
    .RST_N  (RST_N),
    .bus    (bus)
  );

  always #5 pix_clk = ~pix_clk;

  always @(posedge pix_clk) cyc <= cyc + 1;

  function automatic logic [26:0] outs();
    return {bus.out_de, bus.out_hsync, bus.out_vsync, bus.out_rgb};
  endfunction

  task automatic check(input string name, input logic [26:0] act, input logic [26:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got de/hs/vs/rgb=%0b%0b%0b/%06h, expected %0b%0b%0b/%06h", name,
               act[26], act[25], act[24], act[23:0], exp[26], exp[25], exp[24], exp[23:0]);
    end
  endtask

  // Monitor: compare each expected entry when its output cycle arrives.
  always @(negedge pix_clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc + Lat < cyc) begin
      e = sb.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: output slot missed, got none, expected %06h", e.name, e.exp[23:0]);
    end
    if (sb.size() > 0 && sb[0].cyc + Lat == cyc) begin
      e = sb.pop_front();
      check(e.name, outs(), e.exp);
    end
  end

  // Drive one pixel; when chk is set, queue the expected output.
  task automatic px(input int x, input int y, input logic de, input logic hs, input logic vs,
                    input logic chk, input logic [23:0] rgb, input string name);
    exp_t e;
    @(posedge pix_clk);
    #1;
    bus.in_x     = 11'(x);
    bus.in_y     = 10'(y);
    bus.in_de    = de;
    bus.in_hsync = hs;
    bus.in_vsync = vs;
    if (chk) begin
      e.cyc  = cyc;
      e.name = name;
      e.exp  = {de, hs, vs, rgb};
      sb.push_back(e);
    end
  endtask

  task automatic pt(input int x, input int y, input logic [23:0] rgb, input string name);
    px(x, y, 1'b1, 1'b0, 1'b0, 1'b1, rgb, name);
  endtask

  task automatic frame_event();
    px(700, 490, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0, "ev_hi");
    px(700, 490, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0, "ev_lo");
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 10) begin
      @(negedge pix_clk);
      n++;
    end
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
      sb.delete();
    end
  endtask

  localparam logic [23:0] Box = 24'hABCDEF;

  initial begin
    bus.in_x = '0; bus.in_y = '0; bus.in_de = 1'b0; bus.in_hsync = 1'b0;
    bus.in_vsync = 1'b0; bus.mode = 2'd0; bus.colour = '0;

    // Reset with random inputs: outputs must stay 0.
    for (int i = 0; i < 4; i++) begin
      @(posedge pix_clk);
      #1;
      bus.in_x = 11'($urandom_range(0, 639)); bus.in_y = 10'($urandom_range(0, 479));
      bus.in_de = 1'($urandom); bus.in_hsync = 1'($urandom); bus.in_vsync = 1'($urandom);
      bus.mode = 2'($urandom); bus.colour = 24'($urandom);
      @(negedge pix_clk);
      check("reset_outputs", outs(), 27'h0);
    end
    bus.in_de = 1'b0; bus.in_hsync = 1'b0; bus.in_vsync = 1'b0;
    bus.mode = 2'd0; bus.colour = 24'h123456;
    @(negedge pix_clk);
    RST_N = 1'b1;

    // Before any frame-start the latched mode/colour are still their reset values.
    pt(10, 5, 24'h000000, "pre_event_solid");
    px(700, 490, 1'b0, 1'b0, 1'b1, 1'b1, 24'h0, "vsync_delay");
    px(700, 490, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0, "ev_lo");

    // Solid mode, blanking and sync delay.
    pt(10, 5, 24'h123456, "solid");
    px(10, 5, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000000, "blank");
    px(700, 5, 1'b0, 1'b1, 1'b0, 1'b1, 24'h000000, "hsync_delay");
    pt(639, 479, 24'h123456, "solid_corner");

    // Mode change mid-frame has no effect until the next frame start.
    bus.mode = 2'd2;
    pt(32, 0, 24'h123456, "midframe_hold");
    frame_event();
    pt(32, 0, 24'h000000, "check_32_0");
    pt(31, 0, 24'hFFFFFF, "check_31_0");
    pt(32, 32, 24'hFFFFFF, "check_32_32");
    pt(64, 0, 24'hFFFFFF, "check_64_0");

    // Colour bars.
    bus.mode = 2'd1;
    frame_event();
    pt(0, 0, 24'hFFFFFF, "bar_x0");
    pt(79, 0, 24'hFFFFFF, "bar_x79");
    pt(80, 0, 24'hFFFF00, "bar_x80");
    pt(160, 0, 24'h00FFFF, "bar_x160");
    pt(399, 0, 24'hFF00FF, "bar_x399");
    pt(400, 0, 24'hFF0000, "bar_x400");
    pt(639, 0, 24'h000000, "bar_x639");

    // Box mode; four events so far -> box at (4,4).
    bus.mode = 2'd3; bus.colour = Box;
    frame_event();
    pt(4, 4, Box, "box4_in");
    pt(3, 4, 24'h0, "box4_left");
    pt(35, 4, Box, "box4_right_in");
    pt(36, 4, 24'h0, "box4_right_out");
    pt(4, 3, 24'h0, "box4_above");
    pt(4, 35, Box, "box4_bottom_in");
    pt(4, 36, 24'h0, "box4_bottom_out");
    bus.colour = 24'h111111;
    pt(4, 4, Box, "colour_hold");
    bus.colour = Box;

    // 448 events: box_y at its limit.
    for (int i = 5; i <= 448; i++) frame_event();
    pt(448, 448, Box, "box448_in");
    pt(479, 479, Box, "box448_corner");
    pt(480, 448, 24'h0, "box448_right_out");
    pt(448, 447, 24'h0, "box448_above");
    pt(447, 448, 24'h0, "box448_left");
    frame_event();
    pt(449, 447, Box, "box449_in");
    pt(449, 446, 24'h0, "box449_above");
    pt(449, 478, Box, "box449_bottom_in");
    pt(449, 479, 24'h0, "box449_bottom_out");
    pt(480, 447, Box, "box449_right_in");
    pt(481, 447, 24'h0, "box449_right_out");

    // 608 events: box_x at its limit, box_y = 288 on the way back.
    for (int i = 450; i <= 608; i++) frame_event();
    pt(608, 288, Box, "box608_in");
    pt(607, 288, 24'h0, "box608_left");
    pt(639, 319, Box, "box608_corner");
    pt(639, 320, 24'h0, "box608_below");
    pt(608, 287, 24'h0, "box608_above");
    frame_event();
    pt(607, 287, Box, "box609_in");
    pt(606, 287, 24'h0, "box609_left");
    pt(638, 287, Box, "box609_right_in");
    pt(639, 287, 24'h0, "box609_right_out");
    pt(607, 318, Box, "box609_bottom_in");
    pt(607, 319, 24'h0, "box609_bottom_out");
    drain();

    // Asynchronous mid-frame reset; release while vsync is already high.
    px(100, 100, 1'b1, 1'b1, 1'b1, 1'b0, 24'h0, "pre_reset");
    @(posedge pix_clk);
    #3;
    RST_N = 1'b0;
    #1;
    check("async_reset", outs(), 27'h0);
    @(negedge pix_clk);
    bus.in_de = 1'b0; bus.in_hsync = 1'b0;
    RST_N = 1'b1;
    @(negedge pix_clk);
    check("refill_zero", outs(), 27'h0);
    px(700, 490, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0, "ev_lo");
    pt(1, 1, Box, "rst_box_in");
    pt(0, 1, 24'h0, "rst_box_left");
    pt(1, 0, 24'h0, "rst_box_above");
    pt(32, 32, Box, "rst_box_corner");
    pt(33, 1, 24'h0, "rst_box_right_out");
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
